// File: rtl/cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | cmd_pkg : shared types for the host command assembler        |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT1 = 2'd1,
    GOT2 = 2'd2
  } asm_state_t;

  typedef logic [23:0] cmd_t;

  localparam int CMD_BYTES = 3;

endpackage
`default_nettype wire

// File: rtl/inactivity_timer.sv
`default_nettype none
// +--------------------------------------------------------------+
// | inactivity_timer : flags TIMEOUT_CYCLES idle cycles of run   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module inactivity_timer #(
  parameter  int TIMEOUT_CYCLES = 500000,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // A clear in the expiry cycle wins, so a byte arriving on the boundary is never lost.
  assign expire = run && !clear && (r_count == c_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmd_assembler.sv
`default_nettype none
// +--------------------------------------------------------------+
// | cmd_assembler : packs UART bytes into 24-bit host commands   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module cmd_assembler
  import cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  input  logic       clr_cmd_rdy,
  output cmd_t       cmd,
  output logic       cmd_rdy,
  output logic       overrun,
  output logic       timeout
);

  asm_state_t                   r_state;
  logic [(CMD_BYTES-1)*8-1:0]   r_shift;
  logic                         w_idle;
  logic                         w_expire;
  logic                         w_can_load;

  assign w_idle     = (r_state == IDLE);
  assign w_can_load = !cmd_rdy || clr_cmd_rdy;

  inactivity_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_rdy || w_idle),
    .run    (!w_idle),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      cmd     <= '0;
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      // A completion in the same cycle overrides this below.
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (rx_rdy) begin
            r_shift[15:8] <= rx_data;
            r_state       <= GOT1;
          end
        end
        GOT1: begin
          if (rx_rdy) begin
            r_shift[7:0] <= rx_data;
            r_state      <= GOT2;
          end else if (w_expire) begin
            r_state <= IDLE;
            timeout <= 1'b1;
          end
        end
        GOT2: begin
          if (rx_rdy) begin
            r_state <= IDLE;
            if (w_can_load) begin
              cmd     <= {r_shift, rx_data};
              cmd_rdy <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else if (w_expire) begin
            r_state <= IDLE;
            timeout <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/cmd_assembler.md
Name: cmd_assembler

Overview:
- Sits directly upstream of the digital core.
- Collects bytes from the UART receiver and assembles them into the 24-bit host command `cmd`, first byte in bits [23:16].
- Presents `cmd` with a `cmd_rdy` / `clr_cmd_rdy` handshake to the digital core.
- Discards partial commands after an inter-byte timeout and flags commands dropped because the core had not yet consumed the previous one.

Parameters:
- TIMEOUT_CYCLES, 500000, clk cycles of inactivity after which a partial command is discarded (must be >= 2).
- CNT_W, $clog2(TIMEOUT_CYCLES), width of the timeout counter (derived, not overridden).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_rdy  input  1  one-cycle pulse from the UART receiver; rx_data is valid in that cycle.
- rx_data  input  8  received byte.
- clr_cmd_rdy  input  1  one-cycle pulse from the digital core: command consumed.
- cmd  output  24  assembled command; stable whenever cmd_rdy=1.
- cmd_rdy  output  1  command valid, level signal.
- overrun  output  1  one-cycle pulse: a complete command was dropped.
- timeout  output  1  one-cycle pulse: a partial command was discarded.

Behaviour:
- Reset, sampled on posedge while rst=1: cmd=24'h0, cmd_rdy=0, overrun=0, timeout=0, state=IDLE, shift register=0, timeout counter=0. Reset mid-command discards all partial bytes.
- State machine:
  - IDLE, 0 bytes held: rx_rdy -> shift[23:16]=rx_data, go to GOT1.
  - GOT1: rx_rdy -> shift[15:8]=rx_data, go to GOT2.
  - GOT2: rx_rdy -> third byte completes the command; go to IDLE.
- Timeout counter:
  - Cleared on every rx_rdy and whenever state=IDLE.
  - Increments each cycle in GOT1/GOT2.
  - When it equals TIMEOUT_CYCLES-1 with no rx_rdy that cycle: go to IDLE, pulse timeout for 1 cycle, cmd/cmd_rdy unaffected.
  - rx_rdy in the same cycle as expiry: the byte is accepted and the timeout does not fire.
- Completion on the third byte, in cycle N:
  - If cmd_rdy=0, or clr_cmd_rdy=1 in cycle N: cmd <= {shift[23:8], rx_data} and cmd_rdy=1 from cycle N+1.
  - Latency is one clock from the third rx_rdy to cmd_rdy.
  - Otherwise (cmd_rdy=1 and no clr): the new command is dropped, cmd is unchanged, and overrun pulses in cycle N+1.
- clr_cmd_rdy:
  - Without a completion in the same cycle, cmd_rdy <= 0 next cycle; cmd retains its value.
  - With a completion in the same cycle, the new command wins: cmd_rdy stays 1 and cmd updates.
  - clr_cmd_rdy while cmd_rdy=0 is ignored.
- Assembly of the next command proceeds while cmd_rdy=1; only the final load is blocked.
- cmd changes only on a successful load.
- overrun and timeout never assert in the same cycle: a completion implies rx_rdy, which suppresses the timeout.

Decomposition:
- Shared package cmd_pkg holds:
  - typedef enum logic [1:0] {IDLE, GOT1, GOT2} asm_state_t;
  - typedef logic [23:0] cmd_t;
  - localparam CMD_BYTES = 3.
- The timeout counter is a natural sub-module, inactivity_timer: inputs clear and run; output expire pulse; parameter TIMEOUT_CYCLES.
- The FSM, shift register and handshake stay in cmd_assembler.

Test Plan (TIMEOUT_CYCLES=16):
- Basic load: after reset, send 0x01, 0x23, 0x45 spaced 10 cycles apart -> cmd_rdy rises 1 cycle after the third rx_rdy with cmd=24'h012345. Then clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd still 24'h012345.
- Timeout: send 0xAA, wait 16 cycles -> timeout pulses once, cmd_rdy stays 0. Then send 0x10, 0x20, 0x30 -> cmd=24'h102030.
- Byte on expiry boundary: send 0x11, then 0x22 exactly on the expiry cycle, then 0x33 -> no timeout pulse, cmd=24'h112233.
- Overrun: hold cmd=24'h012345 valid with no clr, send 0xDE, 0xAD, 0xBE -> overrun pulses 1 cycle after the third byte, cmd still 24'h012345, cmd_rdy stays 1.
- Simultaneous clr and completion: with cmd_rdy=1, assert clr_cmd_rdy in the same cycle as the third byte of 0x0C, 0x0D, 0x0E -> cmd_rdy stays 1, cmd=24'h0C0D0E, no overrun.
- Reset mid-command: send 0x55, 0x66, assert rst for 1 cycle, then send 0x77, 0x88, 0x99 -> cmd=24'h778899, no timeout or overrun pulses.
